// File: rtl/microwave_timer_ctrl.sv
// Cook-time register, 1 Hz countdown, heater duty cycle and finish beeper for the microwave.
// Optional MICROWAVE_QUICK_START_EN: btnC in SET with zero time loads STEP_UP seconds.
`timescale 1ns/1ps
module microwave_timer_ctrl #(
    parameter int TICK_DIV     = 100_000_000,
    parameter int MAX_TIME     = 5999,
    parameter int STEP_UP      = 30,
    parameter int STEP_DN      = 10,
    parameter int POWER_LEVELS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mode,
    input  logic        btnU,
    input  logic        btnD,
    input  logic        btnL,
    input  logic        btnR,
    input  logic        btnC,
    output logic [13:0] run_time,
    output logic [2:0]  power,
    output logic        heater,
    output logic        beep,
    output logic        done
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);
    localparam logic [14:0]   MAX_T      = 15'(MAX_TIME);
    localparam logic [14:0]   UP_T       = 15'(STEP_UP);
    localparam logic [13:0]   DN_T       = 14'(STEP_DN);
    localparam logic [2:0]    PWR_MAX    = 3'(POWER_LEVELS);

    typedef enum logic [2:0] {
        M_IDLE   = 3'b000,
        M_SET    = 3'b001,
        M_RUN    = 3'b010,
        M_STOP   = 3'b011,
        M_FINISH = 3'b100
    } mode_e;

    mode_e         cur_mode;
    logic [PW-1:0] prescaler;
    logic [PW-1:0] presc_nx;
    logic          tick;
    logic [3:0]    phase;
    logic [3:0]    phase_nx;
    logic [13:0]   run_nx;
    logic [2:0]    power_nx;
    logic [14:0]   up_sum;
    logic [14:0]   run_sum;
    logic          heater_nx;
    logic          beep_nx;
    logic          done_nx;
    int            thresh;

`ifndef MICROWAVE_QUICK_START_EN
    logic unused_btnc;
    assign unused_btnc = btnC;
`endif

    // Undefined mode codes fall back to IDLE.
    always_comb begin
        case (mode)
            3'b001:  cur_mode = M_SET;
            3'b010:  cur_mode = M_RUN;
            3'b011:  cur_mode = M_STOP;
            3'b100:  cur_mode = M_FINISH;
            default: cur_mode = M_IDLE;
        endcase
    end

    always_comb begin
        presc_nx = '0;
        tick     = 1'b0;
        if (cur_mode == M_RUN || cur_mode == M_FINISH) begin
            tick     = (prescaler == PRESC_LAST);
            presc_nx = tick ? '0 : prescaler + 1'b1;
        end
    end

    always_comb begin
        up_sum   = {1'b0, run_time} + UP_T;
        run_sum  = '0;
        run_nx   = run_time;
        power_nx = power;
        phase_nx = phase;
        case (cur_mode)
            M_SET: begin
                if (btnL)
                    run_nx = '0;
                else if (btnU)
                    run_nx = (up_sum > MAX_T) ? MAX_T[13:0] : up_sum[13:0];
                else if (btnD)
                    run_nx = (run_time > DN_T) ? run_time - DN_T : '0;
`ifdef MICROWAVE_QUICK_START_EN
                else if (btnC && run_time == '0)
                    run_nx = UP_T[13:0];
`endif
                if (btnR)
                    power_nx = (power >= PWR_MAX) ? 3'd1 : power + 3'd1;
                phase_nx = '0;
            end
            M_RUN: begin
                // A button add and a tick in the same cycle net out before saturating.
                run_sum = btnU ? up_sum : {1'b0, run_time};
                if (tick && run_time != '0)
                    run_sum = run_sum - 15'd1;
                run_nx = (run_sum > MAX_T) ? MAX_T[13:0] : run_sum[13:0];
                if (tick)
                    phase_nx = (phase == 4'd9) ? 4'd0 : phase + 4'd1;
            end
            M_STOP: begin
                phase_nx = phase;
            end
            M_FINISH: begin
                phase_nx = '0;
            end
            default: begin
                run_nx   = '0;
                power_nx = PWR_MAX;
                phase_nx = '0;
            end
        endcase
    end

    // Outputs are derived from the post-edge state so they line up with run_time/power.
    always_comb begin
        thresh    = (10 * int'(power_nx)) / POWER_LEVELS;
        heater_nx = (cur_mode == M_RUN) && (run_nx != '0) && (int'(phase_nx) < thresh);
        beep_nx   = (cur_mode == M_FINISH) && (presc_nx < PRESC_HALF);
        done_nx   = (cur_mode == M_RUN) && (run_time == 14'd1) && (run_nx == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prescaler <= '0;
            phase     <= '0;
            run_time  <= '0;
            power     <= PWR_MAX;
            heater    <= 1'b0;
            beep      <= 1'b0;
            done      <= 1'b0;
        end else begin
            prescaler <= presc_nx;
            phase     <= phase_nx;
            run_time  <= run_nx;
            power     <= power_nx;
            heater    <= heater_nx;
            beep      <= beep_nx;
            done      <= done_nx;
        end
    end
endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed scenarios with literal expectations, then random
// mode/button traffic, all checked every cycle against an arithmetic model of the timer.
`timescale 1ns/1ps
module tb_microwave_timer_ctrl;
    localparam int TD   = 10;
    localparam int MAXT = 5999;
    localparam int UP   = 30;
    localparam int DN   = 10;
    localparam int PL   = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mode;
    logic        btnU, btnD, btnL, btnR, btnC;
    logic [13:0] run_time;
    logic [2:0]  power;
    logic        heater, beep, done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int exp_rt     = 0;
    int exp_pwr    = 0;
    int m_phase    = 0;
    int m_elapsed  = 0;
    bit exp_heater = 1'b0;
    bit exp_beep   = 1'b0;
    bit exp_done   = 1'b0;

    microwave_timer_ctrl #(
        .TICK_DIV(TD), .MAX_TIME(MAXT), .STEP_UP(UP), .STEP_DN(DN), .POWER_LEVELS(PL)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .btnC(btnC),
        .run_time(run_time), .power(power), .heater(heater), .beep(beep), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input bit u, input bit d, input bit l, input bit r, input bit c);
        btnU = u; btnD = d; btnL = l; btnR = r; btnC = c;
        @(negedge clk);
        btnU = 0; btnD = 0; btnL = 0; btnR = 0; btnC = 0;
    endtask

    // Reference model: prescaler position is just elapsed RUN/FINISH cycles modulo TD.
    always @(posedge clk) begin
        int md, old_rt, v;
        bit tk;
        cyc++;
        if (!reset) begin
            exp_rt = 0; exp_pwr = PL; m_phase = 0; m_elapsed = 0;
            exp_heater = 0; exp_beep = 0; exp_done = 0;
        end else begin
            md     = (int'(mode) > 4) ? 0 : int'(mode);
            old_rt = exp_rt;
            tk     = 0;
            if (md == 2 || md == 4) begin
                m_elapsed++;
                tk = (m_elapsed % TD == 0);
            end else begin
                m_elapsed = 0;
            end
            case (md)
                0: begin exp_rt = 0; exp_pwr = PL; m_phase = 0; end
                1: begin
                    if (btnL) exp_rt = 0;
                    else if (btnU) exp_rt = (exp_rt + UP > MAXT) ? MAXT : exp_rt + UP;
                    else if (btnD) exp_rt = (exp_rt < DN) ? 0 : exp_rt - DN;
`ifdef MICROWAVE_QUICK_START_EN
                    else if (btnC && exp_rt == 0) exp_rt = UP;
`endif
                    if (btnR) exp_pwr = exp_pwr % PL + 1;
                    m_phase = 0;
                end
                2: begin
                    v = exp_rt + (btnU ? UP : 0) - ((tk && exp_rt > 0) ? 1 : 0);
                    exp_rt = (v > MAXT) ? MAXT : v;
                    if (tk) m_phase = (m_phase + 1) % 10;
                end
                4: m_phase = 0;
                default: ;
            endcase
            exp_heater = (md == 2) && (exp_rt != 0) && ((m_phase + 1) * PL <= 10 * exp_pwr);
            exp_beep   = (md == 4) && ((m_elapsed % TD) < TD / 2);
            exp_done   = (md == 2) && (old_rt == 1) && (exp_rt == 0);
        end
    end

    always @(posedge clk) begin
        #1;
        checkOutput("run_time", run_time, exp_rt);
        checkOutput("power", power, exp_pwr);
        checkOutput("heater", heater, exp_heater);
        checkOutput("beep", beep, exp_beep);
        checkOutput("done", done, exp_done);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int m, len;
        reset = 0; mode = 3'b000;
        btnU = 0; btnD = 0; btnL = 0; btnR = 0; btnC = 0;
        runCycles(2);
        reset = 1;
        checkOutput("lit_reset_rt", run_time, 0);
        checkOutput("lit_reset_pwr", power, 5);
        checkOutput("lit_reset_heater", heater, 0);

        mode = 3'b001;
        applyStimulus(1, 0, 0, 0, 0); checkOutput("lit_up1", run_time, 30);
        applyStimulus(1, 0, 0, 0, 0); checkOutput("lit_up2", run_time, 60);
        applyStimulus(1, 0, 0, 0, 0); checkOutput("lit_up3", run_time, 90);
        applyStimulus(0, 1, 0, 0, 0); checkOutput("lit_dn1", run_time, 80);
        applyStimulus(0, 0, 0, 1, 0); checkOutput("lit_pwr1", power, 1);

        mode = 3'b010;
        runCycles(3);
        reset = 0;
        runCycles(2);
        reset = 1; mode = 3'b001;
        checkOutput("lit_midreset_rt", run_time, 0);
        checkOutput("lit_midreset_pwr", power, 5);
        checkOutput("lit_midreset_heater", heater, 0);

        applyStimulus(1, 0, 0, 0, 0);
        mode = 3'b010; runCycles(250);
        checkOutput("lit_run_to5", run_time, 5);
        mode = 3'b001;
        applyStimulus(0, 1, 0, 0, 0); checkOutput("lit_dn_floor", run_time, 0);

        repeat (200) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("lit_sat_200", run_time, 5999);
        mode = 3'b010; runCycles(90);
        checkOutput("lit_run_5990", run_time, 5990);
        mode = 3'b001;
        applyStimulus(1, 0, 0, 0, 0); checkOutput("lit_sat_5990", run_time, 5999);
        applyStimulus(1, 0, 1, 0, 0); checkOutput("lit_l_over_u", run_time, 0);

        applyStimulus(1, 0, 0, 0, 0);
        mode = 3'b010; runCycles(270);
        checkOutput("lit_run_to3", run_time, 3);
        checkOutput("lit_heat_full", heater, 1);
        runCycles(9);  checkOutput("lit_hold3", run_time, 3);
        runCycles(1);  checkOutput("lit_dec2", run_time, 2);
        runCycles(10); checkOutput("lit_dec1", run_time, 1);
        runCycles(10);
        checkOutput("lit_dec0", run_time, 0);
        checkOutput("lit_done_hi", done, 1);
        checkOutput("lit_heat_off0", heater, 0);
        runCycles(1);  checkOutput("lit_done_lo", done, 0);

        mode = 3'b001;
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0); checkOutput("lit_pwr2", power, 2);
        repeat (4) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("lit_120", run_time, 120);
        mode = 3'b010;
        for (int k = 1; k <= 100; k++) begin
            runCycles(1);
            checkOutput("lit_duty", heater, ((k / 10) % 10 < 4) ? 1 : 0);
        end
        checkOutput("lit_110", run_time, 110);
        runCycles(1030); checkOutput("lit_7", run_time, 7);
        mode = 3'b011; runCycles(25);
        checkOutput("lit_stop_rt", run_time, 7);
        checkOutput("lit_stop_heat", heater, 0);
        mode = 3'b010;
        runCycles(9); checkOutput("lit_resume_hold", run_time, 7);
        runCycles(1); checkOutput("lit_resume_dec", run_time, 6);

        mode = 3'b001;
        applyStimulus(0, 0, 1, 0, 0);
        mode = 3'b100;
        for (int k = 1; k <= 30; k++) begin
            runCycles(1);
            checkOutput("lit_beep", beep, ((k % 10) < 5) ? 1 : 0);
        end
        mode = 3'b001; runCycles(1);
        checkOutput("lit_beep_off", beep, 0);

        applyStimulus(0, 0, 0, 0, 1);
`ifdef MICROWAVE_QUICK_START_EN
        checkOutput("lit_quick", run_time, 30);
`else
        checkOutput("lit_btnc_unused", run_time, 0);
`endif
        applyStimulus(0, 0, 1, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("lit_pwr5", power, 5);
        applyStimulus(0, 0, 0, 1, 0); checkOutput("lit_pwr_wrap", power, 1);

        for (int seg = 0; seg < 150; seg++) begin
            m = $urandom_range(0, 7);
            if (m == 4 && exp_rt != 0) m = 1;
            mode = 3'(m);
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                reset = ($urandom_range(0, 249) != 0);
                btnU  = ($urandom_range(0, 7) == 0);
                btnD  = ($urandom_range(0, 5) == 0);
                btnL  = ($urandom_range(0, 15) == 0);
                btnR  = ($urandom_range(0, 7) == 0);
                btnC  = ($urandom_range(0, 7) == 0);
                @(negedge clk);
            end
        end
        reset = 1; btnU = 0; btnD = 0; btnL = 0; btnR = 0; btnC = 0;
        runCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
